// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM data-memory controller.
// Holds the access-phase state type and the default parameter values.
package mem_ctrl_pkg;

    // Access phases: waiting for a request, low half, high half, completion.
    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } mem_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side bus of the SRAM controller.
//   rd_en / wr_en : load / store request from the EXE/MEM register
//   address       : byte address (ALU result)
//   write_data    : store data
//   read_data     : load result, valid while ready=1 after a read completes
//   ready         : 0 while an access is in flight (pipeline freeze = ~ready)
// master = pipeline side, slave = controller side.
interface sram_mem_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one half access.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : restart counting (asserted on the edge entering a phase)
//   last_cycle : high during the final cycle of a WAIT_CYCLES-long phase
module sram_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last_cycle
);

    logic [3:0] count;

    // Saturates at the terminal value so it never wraps while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (!last_cycle) begin
            count <= count + 4'd1;
        end
    end

    assign last_cycle = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit data-memory access into two 16-bit accesses on an
// external asynchronous SRAM, each held for WAIT_CYCLES cycles.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : pipeline-side request/response (slave modport)
//   sram_addr   : halfword address to SRAM
//   sram_dq_out : write data driven to SRAM
//   sram_dq_oe  : 1 = controller drives DQ
//   sram_dq_in  : data returned from SRAM
//   sram_we_n   : SRAM write enable, active-low
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_mem_controller_if.slave   bus,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    mem_state_t         state, next_state;
    logic               op_write, op_write_next;
    logic               load, last_cycle, req, ready;
    logic [31:0]        hw_base;
    logic [SRAM_AW-1:0] lo_addr, hi_addr, addr_next;
    logic [15:0]        dq_next;
    logic               we_n_next, oe_next;
    logic [31:0]        read_q;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .last_cycle(last_cycle)
    );

    assign req = bus.rd_en | bus.wr_en;

    // Halfword index of the word with bit 0 cleared, so address[1:0] drops out.
    assign hw_base = (bus.address - BASE_ADDR) >> 1;
    assign lo_addr = SRAM_AW'(hw_base & ~32'd1);
    assign hi_addr = SRAM_AW'(hw_base | 32'd1);

    always_comb begin
        next_state    = state;
        op_write_next = op_write;
        load          = 1'b0;
        ready         = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    next_state    = LOW;
                    op_write_next = bus.wr_en;
                    load          = 1'b1;
                end
            end
            LOW: begin
                if (last_cycle) begin
                    next_state = HIGH;
                    load       = 1'b1;
                end
            end
            HIGH: begin
                if (last_cycle) next_state = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Pin values are derived from the phase being entered so they are
        // registered and already valid in the first cycle of that phase.
        addr_next = sram_addr;
        dq_next   = sram_dq_out;
        we_n_next = 1'b1;
        oe_next   = 1'b0;
        if (next_state == LOW) begin
            addr_next = lo_addr;
            dq_next   = bus.write_data[15:0];
            we_n_next = ~op_write_next;
            oe_next   = op_write_next;
        end else if (next_state == HIGH) begin
            addr_next = hi_addr;
            dq_next   = bus.write_data[31:16];
            we_n_next = ~op_write_next;
            oe_next   = op_write_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            read_q      <= '0;
        end else begin
            state       <= next_state;
            op_write    <= op_write_next;
            sram_addr   <= addr_next;
            sram_dq_out <= dq_next;
            sram_we_n   <= we_n_next;
            sram_dq_oe  <= oe_next;
            if (!op_write && last_cycle) begin
                if (state == LOW)       read_q[15:0]  <= sram_dq_in;
                else if (state == HIGH) read_q[31:16] <= sram_dq_in;
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.read_data = read_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: behavioural async SRAM plus a
// word-level reference model of memory contents and the expected load result.
module tb_sram_mem_controller;

    localparam int unsigned W        = 2;
    localparam int unsigned AW       = 18;
    localparam logic [31:0] BASE     = 32'd1024;
    localparam int unsigned HW_COUNT = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  sram_addr;
    logic [15:0]    sram_dq_out;
    logic [15:0]    sram_dq_in;
    logic           sram_dq_oe;
    logic           sram_we_n;

    sram_mem_controller_if bus ();

    sram_mem_controller #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(W),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // Initial SRAM content is a known function of the halfword address.
    function automatic logic [15:0] pattern(input int unsigned hw);
        return 16'(hw) ^ 16'hA5C3;
    endfunction

    logic [15:0] sram_arr [HW_COUNT];
    assign sram_dq_in = sram_arr[sram_addr];

    initial begin
        for (int unsigned i = 0; i < HW_COUNT; i++) sram_arr[i] = pattern(i);
        forever begin
            @(posedge clk);
            if (!sram_we_n && sram_dq_oe) sram_arr[sram_addr] = sram_dq_out;
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: words written so far, keyed by low halfword address.
    logic [31:0] ref_words [int unsigned];
    logic [31:0] model_rd;

    function automatic int unsigned lo_hw(input logic [31:0] a);
        logic [31:0] off;
        int unsigned word;
        off  = a - BASE;
        word = off / 4;
        return (word * 2) % HW_COUNT;
    endfunction

    function automatic logic [31:0] expect_word(input int unsigned lo);
        if (ref_words.exists(lo)) return ref_words[lo];
        return {pattern(lo + 1), pattern(lo)};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.rd_en = 1'b0;
            bus.wr_en = 1'b0;
            @(negedge clk);
            check("idle_ready", bus.ready, 1);
            check("idle_we_n", sram_we_n, 1);
            check("idle_oe", sram_dq_oe, 0);
        end
    endtask

    // One access; cycle 0 is the IDLE cycle in which the request appears.
    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data);
        int unsigned lo;
        bit          is_wr;
        bit          half;
        lo    = lo_hw(addr);
        is_wr = wr;
        @(posedge clk); #1;
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = data;
        @(negedge clk);
        check("c0_ready", bus.ready, 0);
        check("c0_we_n", sram_we_n, 1);
        for (int c = 1; c <= 2 * W; c++) begin
            @(negedge clk);
            half = (c > W);
            check("busy_ready", bus.ready, 0);
            check("busy_addr", sram_addr, lo + half);
            check("busy_we_n", sram_we_n, !is_wr);
            check("busy_oe", sram_dq_oe, is_wr);
            if (is_wr) check("busy_dq_out", sram_dq_out, half ? data[31:16] : data[15:0]);
        end
        if (is_wr) ref_words[lo] = data;
        else       model_rd = expect_word(lo);
        @(negedge clk);
        check("done_ready", bus.ready, 1);
        check("done_we_n", sram_we_n, 1);
        check("done_oe", sram_dq_oe, 0);
        check("done_read_data", bus.read_data, model_rd);
        if (is_wr) begin
            check("sram_lo", sram_arr[lo], data[15:0]);
            check("sram_hi", sram_arr[lo + 1], data[31:16]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        model_rd       = '0;
        #12;
        check("rst_ready", bus.ready, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_out", sram_dq_out, 0);
        check("rst_read_data", bus.read_data, 0);
        @(negedge clk);
        rst = 1'b1;

        idle(10);
        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        idle(1);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        check("load_1028", model_rd, 32'hDEADBEEF);
        idle(1);
        // Both enables: write wins, read_data keeps the previous load value.
        access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        idle(1);
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        idle(1);
        // Back-to-back loads: second request present in the cycle after DONE.
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        idle(1);
        // Address below BASE wraps into the top of the SRAM.
        access(1'b1, 1'b0, 32'd0, 32'hCAFEF00D);
        idle(1);
        access(1'b0, 1'b1, 32'd3, 32'h0);
        idle(1);

        // Asynchronous reset in the middle of the low half of a store.
        @(posedge clk); #1;
        bus.wr_en      = 1'b1;
        bus.address    = BASE + 32'd800;
        bus.write_data = 32'hA5A5_5A5A;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_we_n", sram_we_n, 0);
        #2 rst = 1'b0;
        #1;
        check("abort_we_n", sram_we_n, 1);
        check("abort_oe", sram_dq_oe, 0);
        check("abort_addr", sram_addr, 0);
        check("abort_read_data", bus.read_data, 0);
        bus.wr_en = 1'b0;
        #1;
        check("abort_ready", bus.ready, 1);
        model_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        access(1'b0, 1'b1, 32'd1028, 32'h0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            int unsigned op;
            int unsigned gap;
            logic [31:0] a;
            op  = $urandom_range(0, 2);
            a   = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            access(op != 0, op != 1, a, $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(int'(gap));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
